// File: rtl/ex_stage_if.sv
// Data-memory request bus between the execute stage and the data memory.
interface ex_stage_if;
  logic        dmem_read_ready;
  logic        dmem_write_ready;
  logic        dmem_read_valid;
  logic        dmem_write_valid;
  logic [31:0] dmem_read_address;
  logic [31:0] dmem_write_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_byte;

  modport master (
    output dmem_read_ready, dmem_write_ready,
    output dmem_read_address, dmem_write_address, dmem_write_data, dmem_write_byte,
    input  dmem_read_valid, dmem_write_valid
  );

  modport slave (
    input  dmem_read_ready, dmem_write_ready,
    input  dmem_read_address, dmem_write_address, dmem_write_data, dmem_write_byte,
    output dmem_read_valid, dmem_write_valid
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I stage 2: ALU/branch evaluation, data-memory issue, wrong-path squash
// and the registered payload handed to write-back.
module ex_stage #(
  parameter logic [31:0] RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [3:0]  id_alu_op,
  input  logic [2:0]  id_funct3,
  input  logic        id_use_imm,
  input  logic        id_use_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [4:0]  id_dest_reg,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_branch,
  input  logic        id_jal,
  input  logic        id_jalr,
  output logic        ex_stall,
  output logic        ex_redirect,
  output logic [31:0] ex_target,
  ex_stage_if.master  dmem,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg_sel,
  output logic        wb_alu_to_reg,
  output logic        wb_mem_to_reg,
  output logic [2:0]  wb_alu_operation,
  output logic [1:0]  wb_read_address,
  output logic        wb_branch
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]  state;
  logic [1:0]  squash_cnt;
  logic        live;
  logic [31:0] op_a, op_b, alu_out, result, ea;
  logic [4:0]  shamt;
  logic        cond, taken, read_req, write_req, accepted;
  logic [31:0] store_data;
  logic [3:0]  store_byte;

  assign live  = id_valid && (squash_cnt == 2'd0);
  assign op_a  = id_use_pc ? id_pc : id_rs1_val;
  assign op_b  = id_use_imm ? id_imm : id_rs2_val;
  assign shamt = op_b[4:0];
  assign ea    = id_rs1_val + id_imm;

  always_comb begin
    alu_out = '0;
    case (id_alu_op)
      4'd0:  alu_out = op_a + op_b;
      4'd1:  alu_out = op_a - op_b;
      4'd2:  alu_out = op_a << shamt;
      4'd3:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_out = {31'd0, op_a < op_b};
      4'd5:  alu_out = op_a ^ op_b;
      4'd6:  alu_out = op_a >> shamt;
      4'd7:  alu_out = $unsigned($signed(op_a) >>> shamt);
      4'd8:  alu_out = op_a | op_b;
      4'd9:  alu_out = op_a & op_b;
      4'd10: alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  assign result = (id_jal || id_jalr) ? id_pc + 32'd4 : alu_out;

  always_comb begin
    cond = 1'b0;
    case (id_funct3)
      3'b000: cond = id_rs1_val == id_rs2_val;
      3'b001: cond = id_rs1_val != id_rs2_val;
      3'b100: cond = $signed(id_rs1_val) <  $signed(id_rs2_val);
      3'b101: cond = $signed(id_rs1_val) >= $signed(id_rs2_val);
      3'b110: cond = id_rs1_val <  id_rs2_val;
      3'b111: cond = id_rs1_val >= id_rs2_val;
      default: cond = 1'b0;
    endcase
  end

  assign taken       = (id_branch && cond) || id_jal || id_jalr;
  assign ex_redirect = live && taken;
  assign ex_target   = !ex_redirect ? RESET :
                       id_jalr      ? (ea & ~32'd1) : id_pc + id_imm;

  always_comb begin
    store_data = id_rs2_val;
    store_byte = 4'b1111;
    case (id_funct3[1:0])
      2'b00: begin
        store_data = {4{id_rs2_val[7:0]}};
        store_byte = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        store_data = {2{id_rs2_val[15:0]}};
        store_byte = 4'b0011 << {ea[1], 1'b0};
      end
      default: ;
    endcase
  end

  // A load takes precedence so the two strobes can never be high together.
  assign read_req  = live && id_mem_read;
  assign write_req = live && id_mem_write && !id_mem_read;
  assign accepted  = (read_req && dmem.dmem_read_valid) || (write_req && dmem.dmem_write_valid);
  // Stage-1 inputs are frozen while stalled, so the request re-derives identically in MEM_WAIT.
  assign ex_stall  = (read_req || write_req || (state == MEM_WAIT)) && !accepted;

  assign dmem.dmem_read_ready    = read_req;
  assign dmem.dmem_write_ready   = write_req;
  assign dmem.dmem_read_address  = ea;
  assign dmem.dmem_write_address = ea;
  assign dmem.dmem_write_data    = store_data;
  assign dmem.dmem_write_byte    = store_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      squash_cnt       <= '0;
      wb_result        <= '0;
      wb_dest_reg_sel  <= '0;
      wb_alu_to_reg    <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_alu_operation <= '0;
      wb_read_address  <= '0;
      wb_branch        <= 1'b0;
    end else begin
      state <= ex_stall ? MEM_WAIT : RUN;
      if (!ex_stall) begin
        if (ex_redirect)
          squash_cnt <= 2'd2;
        else if (id_valid && squash_cnt != 2'd0)
          squash_cnt <= squash_cnt - 2'd1;
      end
      wb_result        <= result;
      wb_dest_reg_sel  <= id_dest_reg;
      wb_alu_operation <= id_funct3;
      wb_read_address  <= ea[1:0];
      wb_alu_to_reg    <= !ex_stall && live && id_reg_write;
      wb_mem_to_reg    <= !ex_stall && live && id_mem_read;
      wb_branch        <= !ex_stall && live && taken;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected write-back payloads are queued when
// an instruction is driven and compared when it leaves the stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_use_imm, id_use_pc;
  logic [31:0] id_imm, id_rs1_val, id_rs2_val;
  logic [4:0]  id_dest_reg;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        id_branch, id_jal, id_jalr;
  logic        ex_stall, ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg_sel;
  logic        wb_alu_to_reg, wb_mem_to_reg, wb_branch;
  logic [2:0]  wb_alu_operation;
  logic [1:0]  wb_read_address;

  ex_stage_if dmem ();

  ex_stage #(.RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_use_imm(id_use_imm),
    .id_use_pc(id_use_pc), .id_imm(id_imm), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_dest_reg(id_dest_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .ex_stall(ex_stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .dmem(dmem), .wb_result(wb_result),
    .wb_dest_reg_sel(wb_dest_reg_sel), .wb_alu_to_reg(wb_alu_to_reg),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_operation(wb_alu_operation),
    .wb_read_address(wb_read_address), .wb_branch(wb_branch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int wfires = 0;
  int rfires = 0;
  logic [44:0] sb[$];
  logic [44:0] exp_wb;
  logic [44:0] wb_bus;

  assign wb_bus = {wb_result, wb_dest_reg_sel, wb_alu_to_reg, wb_mem_to_reg,
                   wb_alu_operation, wb_read_address, wb_branch};

  always @(posedge clk) begin
    if (dmem.dmem_write_ready && dmem.dmem_write_valid) wfires++;
    if (dmem.dmem_read_ready && dmem.dmem_read_valid) rfires++;
  end

  function automatic logic [44:0] pack(input logic [31:0] r, input logic [4:0] d,
                                       input logic a2r, input logic m2r,
                                       input logic [2:0] f3, input logic [1:0] ra,
                                       input logic br);
    return {r, d, a2r, m2r, f3, ra, br};
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << b[4:0];
      4'd3: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd4: r = {31'd0, a < b};
      4'd5: r = a ^ b;
      4'd6: r = a >> b[4:0];
      4'd7: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]};
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = '0; id_alu_op = '0; id_funct3 = '0;
    id_use_imm = 0; id_use_pc = 0; id_imm = '0; id_rs1_val = '0; id_rs2_val = '0;
    id_dest_reg = '0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_branch = 0; id_jal = 0; id_jalr = 0;
    dmem.dmem_read_valid = 0; dmem.dmem_write_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    n_cmp++;
    if (wb_bus !== 45'd0) begin n_fail++; $display("FAIL reset_wb: got %h expected 0", wb_bus); end
    n_cmp++;
    if ({ex_stall, ex_redirect, dmem.dmem_read_ready, dmem.dmem_write_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {ex_stall, ex_redirect, dmem.dmem_read_ready, dmem.dmem_write_ready});
    end
    reset = 0;
  endtask

  task automatic test_alu();
    clear_inputs();
    id_valid = 1; id_alu_op = 4'd0; id_rs1_val = 32'd5; id_rs2_val = 32'd7;
    id_dest_reg = 5'd3; id_reg_write = 1;
    sb.push_back(pack(32'd12, 5'd3, 1, 0, 3'd0, 2'd1, 0));
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL add: got %h expected %h", wb_bus, exp_wb); end
    id_alu_op = 4'd7; id_rs1_val = 32'h8000_0000; id_use_imm = 1; id_imm = 32'd4;
    id_dest_reg = 5'd9;
    sb.push_back(pack(32'hF800_0000, 5'd9, 1, 0, 3'd0, 2'd0, 0));
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL sra: got %h expected %h", wb_bus, exp_wb); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    clear_inputs();
    id_valid = 1; id_reg_write = 1;
    for (int i = 0; i < 12; i++) begin
      id_alu_op = 4'($urandom_range(0, 10));
      id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
      id_dest_reg = 5'($urandom_range(1, 31));
      ea = id_rs1_val + id_imm;
      sb.push_back(pack(alu_model(id_alu_op, id_rs1_val, id_rs2_val), id_dest_reg,
                        1, 0, 3'd0, ea[1:0], 0));
      #3;
      n_cmp++;
      if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b expected 0", ex_stall); end
      tick();
      exp_wb = sb.pop_front();
      n_cmp++;
      if (wb_bus !== exp_wb) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got %h expected %h", id_alu_op, wb_bus, exp_wb);
      end
    end
  endtask

  task automatic test_store_stall();
    int w0;
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_funct3 = 3'b000; id_use_imm = 1;
    id_rs1_val = 32'h100; id_imm = 32'd3; id_rs2_val = 32'hAB;
    w0 = wfires;
    sb.push_back(pack(32'h103, 5'd0, 0, 0, 3'b000, 2'd3, 0));
    #3;
    n_cmp++;
    if ({dmem.dmem_write_address, dmem.dmem_write_byte, dmem.dmem_write_data} !==
        {32'h103, 4'b1000, 32'hABAB_ABAB}) begin
      n_fail++;
      $display("FAIL sb_req: got %h/%b/%h expected 103/1000/abababab",
               dmem.dmem_write_address, dmem.dmem_write_byte, dmem.dmem_write_data);
    end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) #3;
      n_cmp++;
      if ({ex_stall, dmem.dmem_write_ready, dmem.dmem_read_ready} !== 3'b110) begin
        n_fail++;
        $display("FAIL sb_stall%0d: got %b expected 110", i,
                 {ex_stall, dmem.dmem_write_ready, dmem.dmem_read_ready});
      end
      tick();
      n_cmp++;
      if ({wb_alu_to_reg, wb_mem_to_reg, wb_branch} !== 3'b000) begin
        n_fail++;
        $display("FAIL sb_bubble%0d: got %b expected 000", i,
                 {wb_alu_to_reg, wb_mem_to_reg, wb_branch});
      end
    end
    dmem.dmem_write_valid = 1;
    #3;
    n_cmp++;
    if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL sb_release: got %b expected 0", ex_stall); end
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL sb_wb: got %h expected %h", wb_bus, exp_wb); end
    clear_inputs();
    tick();
    n_cmp++;
    if (wfires - w0 !== 1) begin n_fail++; $display("FAIL sb_count: got %0d expected 1", wfires - w0); end
  endtask

  task automatic test_load();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_funct3 = 3'b001; id_use_imm = 1;
    id_rs1_val = 32'h200; id_imm = 32'd2; id_dest_reg = 5'd5;
    dmem.dmem_read_valid = 1;
    sb.push_back(pack(32'h202, 5'd5, 1, 1, 3'b001, 2'd2, 0));
    #3;
    n_cmp++;
    if ({ex_stall, dmem.dmem_read_ready, dmem.dmem_write_ready, dmem.dmem_read_address} !==
        {3'b010, 32'h202}) begin
      n_fail++;
      $display("FAIL lh_req: got %b/%h expected 010/202",
               {ex_stall, dmem.dmem_read_ready, dmem.dmem_write_ready}, dmem.dmem_read_address);
    end
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL lh_wb: got %h expected %h", wb_bus, exp_wb); end
  endtask

  task automatic test_branch_squash();
    int w0;
    clear_inputs();
    id_valid = 1; id_branch = 1; id_funct3 = 3'b000; id_alu_op = 4'd1;
    id_pc = 32'h40; id_imm = 32'h20; id_rs1_val = 32'd9; id_rs2_val = 32'd9;
    sb.push_back(pack(32'd0, 5'd0, 0, 0, 3'b000, 2'd1, 1));
    #3;
    n_cmp++;
    if ({ex_redirect, ex_target} !== {1'b1, 32'h60}) begin
      n_fail++;
      $display("FAIL beq_redirect: got %b/%h expected 1/60", ex_redirect, ex_target);
    end
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL beq_wb: got %h expected %h", wb_bus, exp_wb); end
    // wrong-path SW
    clear_inputs();
    id_valid = 1; id_mem_write = 1; id_funct3 = 3'b010; id_rs1_val = 32'h300;
    id_rs2_val = 32'h55; dmem.dmem_write_valid = 1;
    w0 = wfires;
    #3;
    n_cmp++;
    if ({ex_stall, dmem.dmem_write_ready, dmem.dmem_read_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL squash_sw: got %b expected 000",
               {ex_stall, dmem.dmem_write_ready, dmem.dmem_read_ready});
    end
    tick();
    n_cmp++;
    if ({wb_alu_to_reg, wb_mem_to_reg, wb_branch} !== 3'b000 || wfires != w0) begin
      n_fail++;
      $display("FAIL squash_sw_wb: got %b/%0d expected 000/0",
               {wb_alu_to_reg, wb_mem_to_reg, wb_branch}, wfires - w0);
    end
    // wrong-path JAL must neither redirect nor reload the squash counter
    clear_inputs();
    id_valid = 1; id_jal = 1; id_reg_write = 1; id_dest_reg = 5'd1; id_pc = 32'h48; id_imm = 32'h100;
    #3;
    n_cmp++;
    if (ex_redirect !== 1'b0) begin n_fail++; $display("FAIL squash_jal: got %b expected 0", ex_redirect); end
    tick();
    n_cmp++;
    if ({wb_alu_to_reg, wb_branch} !== 2'b00) begin
      n_fail++;
      $display("FAIL squash_jal_wb: got %b expected 00", {wb_alu_to_reg, wb_branch});
    end
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs1_val = 32'd1; id_rs2_val = 32'd2; id_dest_reg = 5'd4;
    sb.push_back(pack(32'd3, 5'd4, 1, 0, 3'd0, 2'd1, 0));
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL third_live: got %h expected %h", wb_bus, exp_wb); end
  endtask

  task automatic test_jalr();
    clear_inputs();
    id_valid = 1; id_jalr = 1; id_reg_write = 1; id_dest_reg = 5'd1; id_use_imm = 1;
    id_pc = 32'h80; id_rs1_val = 32'h1001; id_imm = 32'd4;
    sb.push_back(pack(32'h84, 5'd1, 1, 0, 3'd0, 2'd1, 1));
    #3;
    n_cmp++;
    if ({ex_redirect, ex_target} !== {1'b1, 32'h1004}) begin
      n_fail++;
      $display("FAIL jalr_target: got %b/%h expected 1/1004", ex_redirect, ex_target);
    end
    tick();
    exp_wb = sb.pop_front();
    n_cmp++;
    if (wb_bus !== exp_wb) begin n_fail++; $display("FAIL jalr_wb: got %h expected %h", wb_bus, exp_wb); end
  endtask

  task automatic test_reset_mem_wait();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_funct3 = 3'b010;
    id_rs1_val = 32'h400; id_dest_reg = 5'd7;
    tick();
    n_cmp++;
    if ({ex_stall, dmem.dmem_read_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL lw_wait: got %b expected 11", {ex_stall, dmem.dmem_read_ready});
    end
    reset = 1;
    clear_inputs();
    tick();
    n_cmp++;
    if ({ex_stall, dmem.dmem_read_ready, dmem.dmem_write_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_wait_ctrl: got %b expected 000",
               {ex_stall, dmem.dmem_read_ready, dmem.dmem_write_ready});
    end
    n_cmp++;
    if (wb_bus !== 45'd0) begin n_fail++; $display("FAIL rst_wait_wb: got %h expected 0", wb_bus); end
    reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_store_stall();
    test_load();
    test_branch_squash();
    test_jalr();
    test_reset_mem_wait();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Stage 2 (execute/memory-issue) of the three-stage RV32I pipeline. It takes a decoded instruction from stage 1, computes the ALU/branch result, and issues the data-memory request. It squashes wrong-path instructions after a taken branch and registers everything stage 3 (`wb`) needs. It stalls stage 1 while a memory request is unacknowledged.

## Interface
- `RESET`, 32'h0000_0000: restart PC; the redirect target after reset is unused.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: stage 1 presents an instruction.
- `id_pc` in 32: PC of the instruction.
- `id_alu_op` in 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- `id_funct3` in 3: branch condition, or load/store size.
- `id_use_imm`, `id_use_pc` in 1 each: operand B = `id_imm`; operand A = `id_pc`.
- `id_imm` in 32: sign-extended immediate.
- `id_rs1_val`, `id_rs2_val` in 32 each: register operands, already bypassed by `wb`.
- `id_dest_reg` in 5: destination register.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1 each: instruction class flags.
- `id_branch`, `id_jal`, `id_jalr` in 1 each: control-transfer class.
- `ex_stall` out 1: stage 1 must hold its outputs.
- `ex_redirect` out 1: one-cycle pulse on a taken branch or jump.
- `ex_target` out 32: redirect PC.
- `dmem_read_ready`, `dmem_write_ready` out 1 each: request strobes.
- `dmem_read_valid`, `dmem_write_valid` in 1 each: request accepted. Read data arrives the following cycle.
- `dmem_read_address`, `dmem_write_address` out 32: byte addresses.
- `dmem_write_data` out 32: lane-replicated store data.
- `dmem_write_byte` out 4: byte strobes.
- `wb_result` out 32, `wb_dest_reg_sel` out 5, `wb_alu_to_reg` out 1, `wb_mem_to_reg` out 1, `wb_alu_operation` out 3, `wb_read_address` out 2, `wb_branch` out 1: registered stage-3 payload.

## Operation
- Operands:
  - A = `id_use_pc` ? `id_pc` : `id_rs1_val`.
  - B = `id_use_imm` ? `id_imm` : `id_rs2_val`.
  - Shift amount = B[4:0].
  - SLT is signed; SLTU is unsigned.
  - Results are truncated to 32 bits; no overflow flag.
- Branch conditions (`id_funct3`):
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- Targets:
  - branch/jal: `id_pc+id_imm`.
  - jalr: `(id_rs1_val+id_imm) & ~1`.
  - jal/jalr write `id_pc+4` as the result.
- Effective address EA = `id_rs1_val+id_imm`. It drives both `dmem_read_address` and `dmem_write_address`.
- Store strobes; misaligned accesses are not trapped and the low bits are ignored as shown:
  - SB: `4'b0001<<EA[1:0]`, data = byte ×4.
  - SH: `4'b0011<<{EA[1],1'b0}`, data = half ×2.
  - SW: `4'b1111`.
- Live instruction = `id_valid && squash_cnt==0`.
- Squash:
  - A taken branch/jump loads `squash_cnt`=2.
  - Each following cycle that advances while `id_valid` is high decrements it. That instruction becomes a bubble: no memory strobe, no register write.
  - A squashed instruction never redirects.
- FSM:
  - RUN:
    - A live memory op raises its ready strobe combinationally.
    - If the matching valid is high in the same cycle, it advances.
    - Otherwise it goes to MEM_WAIT with `ex_stall`=1.
  - MEM_WAIT:
    - Ready stays high; address, data and strobe are held stable from the stage-1 inputs, which are frozen by the stall.
    - On valid it advances and returns to RUN.
  - Non-memory live instructions and bubbles advance every cycle.
- Advance edge:
  - `wb_*` register the payload.
  - `wb_alu_to_reg` = `id_reg_write` & live.
  - `wb_mem_to_reg` = `id_mem_read` & live.
  - `wb_read_address` = EA[1:0]; `wb_alu_operation` = `id_funct3`.
  - `wb_branch` = taken & live.
  - A bubble registers `wb_alu_to_reg`=0 and `wb_branch`=0.
- While `ex_stall` is high, `wb_*` are re-registered as a bubble (`wb_alu_to_reg`=0, `wb_mem_to_reg`=0, `wb_branch`=0). The held instruction therefore writes back exactly once.

## Timing
- Reset: FSM=RUN, `squash_cnt`=0, all `wb_*` and `ex_redirect`=0.
  - Combinational outputs then follow the inputs.
  - Reset has priority mid-MEM_WAIT: the request is dropped and the strobes fall in the cycle after reset is sampled.
- Latency: one cycle from acceptance to `wb_*`. `ex_redirect`/`ex_target` are combinational in the execute cycle.
- Minimum memory op takes 1 cycle (valid in the same cycle). Each cycle without valid adds one stall cycle.
- A store and a load are never outstanding together; at most one strobe is high.
- A taken branch while `squash_cnt`≠0 is itself squashed; the counter is not reloaded.
- `ex_stall` is high only in MEM_WAIT, or in RUN while a live memory op lacks valid.

## Test plan
- ADD x3 = 5+7 -> next cycle `wb_result`=12, `wb_dest_reg_sel`=3, `wb_alu_to_reg`=1. SRA of 0x8000_0000 by 4 -> 0xF800_0000.
- SB, rs1=0x100, imm=3, rs2=0xAB -> address 0x103, strobe 4'b1000, data 0xABABABAB. With valid held low 3 cycles: `ex_stall` high 3 cycles, exactly one write, then advance.
- LH at EA 0x202 with valid in the same cycle -> `wb_mem_to_reg`=1, `wb_read_address`=2, `wb_alu_operation`=001, no stall.
- BEQ taken at PC 0x40, imm 0x20 -> `ex_redirect`=1, target 0x60. The next two instructions (one a SW) produce no strobes and `wb_alu_to_reg`=0; the third executes.
- JALR, rs1=0x1001, imm=4 -> target 0x1004, `wb_result`=PC+4.
- `reset` asserted during MEM_WAIT -> next cycle strobes low, `ex_stall`=0, all `wb_*`=0.
